block_transfer_sequencer: RTL and testbench



---
 rtl/block_transfer_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_block_transfer_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_transfer_sequencer.sv
// Block load/store sequencer: walks a 16-bit register list, issues one word
// access per listed register in ascending register order, then optionally
// writes the updated base address back to the register file.
module block_transfer_sequencer #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         is_load,
   input  logic         pre_index,
   input  logic         up,
   input  logic         writeback,
   input  logic [3:0]   base_reg,
   input  logic [N-1:0] base_addr,
   input  logic [15:0]  reg_list,
   output logic         busy,
   output logic         done,
   output logic [3:0]   rf_read_reg,
   input  logic [N-1:0] rf_read_data,
   output logic [3:0]   rf_write_reg,
   output logic [N-1:0] rf_write_data,
   output logic         rf_reg_write,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic         mem_ack,
   input  logic [N-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_LWR  = 3'd2,
      ST_BWB  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [N-1:0] C_STEP = {{(N-3){1'b0}}, 3'b100};

   // Number of set bits in a register list (0..16).
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   // Index of the lowest set bit; 0 for an empty list.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   state_t       r_state;
   state_t       w_state_nxt;

   logic         r_is_load;
   logic         r_wb;
   logic [3:0]   r_base_reg;
   logic [15:0]  r_list;
   logic [N-1:0] r_addr;
   logic [N-1:0] r_final;
   logic [3:0]   r_wr_reg;
   logic [N-1:0] r_wr_data;

   logic [4:0]   w_cnt;
   logic [N-1:0] w_span;
   logic [N-1:0] w_start_addr;
   logic [N-1:0] w_final;
   logic         w_wb_eff;
   logic [3:0]   w_cur_reg;
   logic [15:0]  w_list_rest;
   logic         w_last;

   // Start-of-transfer arithmetic from the live inputs; only used when start is accepted.
   always_comb begin
      w_cnt  = popcount16(reg_list);
      w_span = {{(N-7){1'b0}}, w_cnt, 2'b00};
      if (up) begin
         w_start_addr = pre_index ? (base_addr + C_STEP) : base_addr;
         w_final      = base_addr + w_span;
      end else begin
         w_start_addr = pre_index ? (base_addr - w_span) : (base_addr - w_span + C_STEP);
         w_final      = base_addr - w_span;
      end
      // A load that targets the base register keeps the loaded value.
      w_wb_eff = writeback & ~(is_load & reg_list[base_reg]);
   end

   // Current register and what remains of the list once it is transferred.
   always_comb begin
      w_cur_reg   = lowest_set(r_list);
      w_list_rest = r_list & (r_list - 16'd1);
      w_last      = (w_list_rest == 16'd0);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decision.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = (w_cnt == 5'd0) ? ST_DONE : ST_REQ;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!mem_ack) begin
               w_state_nxt = ST_REQ;
            end else if (r_is_load) begin
               w_state_nxt = ST_LWR;
            end else if (!w_last) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_state_nxt = r_wb ? ST_BWB : ST_DONE;
            end
         end
         ST_LWR: begin
            if (r_list != 16'd0) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_state_nxt = r_wb ? ST_BWB : ST_DONE;
            end
         end
         ST_BWB:  w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Transfer context: latched at start, list/address stepped on each ack,
   // register-file write port loaded with load data or the final base.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_is_load  <= 1'b0;
         r_wb       <= 1'b0;
         r_base_reg <= 4'd0;
         r_list     <= 16'd0;
         r_addr     <= {N{1'b0}};
         r_final    <= {N{1'b0}};
         r_wr_reg   <= 4'd0;
         r_wr_data  <= {N{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_is_load  <= is_load;
                  r_wb       <= w_wb_eff;
                  r_base_reg <= base_reg;
                  r_list     <= reg_list;
                  r_addr     <= w_start_addr;
                  r_final    <= w_final;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  r_list <= w_list_rest;
                  r_addr <= r_addr + C_STEP;
                  if (r_is_load) begin
                     r_wr_reg  <= w_cur_reg;
                     r_wr_data <= mem_rdata;
                  end else if (w_last && r_wb) begin
                     r_wr_reg  <= r_base_reg;
                     r_wr_data <= r_final;
                  end
               end
            end
            ST_LWR: begin
               // The loaded value is written this cycle; stage the base for BWB.
               if ((r_list == 16'd0) && r_wb) begin
                  r_wr_reg  <= r_base_reg;
                  r_wr_data <= r_final;
               end
            end
            default: begin
               r_list <= r_list;
            end
         endcase
      end
   end

   assign busy          = (r_state == ST_REQ) || (r_state == ST_LWR) || (r_state == ST_BWB);
   assign done          = (r_state == ST_DONE);
   assign mem_req       = (r_state == ST_REQ);
   assign mem_we        = (r_state == ST_REQ) && !r_is_load;
   assign mem_addr      = (r_state == ST_REQ) ? r_addr : {N{1'b0}};
   assign mem_wdata     = rf_read_data;
   assign rf_read_reg   = w_cur_reg;
   assign rf_reg_write  = (r_state == ST_LWR) || (r_state == ST_BWB);
   assign rf_write_reg  = r_wr_reg;
   assign rf_write_data = r_wr_data;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Randomized self-checking bench for block_transfer_sequencer. The bench owns
// the register file and a memory responder; expectations come from a
// list-level model of the block transfer.
module tb_block_transfer_sequencer;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         is_load = 1'b0;
   logic         pre_index = 1'b0;
   logic         up = 1'b0;
   logic         writeback = 1'b0;
   logic [3:0]   base_reg = 4'd0;
   logic [N-1:0] base_addr = '0;
   logic [15:0]  reg_list = 16'd0;
   logic         busy, done;
   logic [3:0]   rf_read_reg, rf_write_reg;
   logic [N-1:0] rf_read_data, rf_write_data;
   logic         rf_reg_write, mem_req, mem_we;
   logic [N-1:0] mem_addr, mem_wdata;
   logic         mem_ack = 1'b0;
   logic [N-1:0] mem_rdata = '0;

   logic [N-1:0] rf_mem [16];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int wr_pulses = 0;
   int run_id = 0;

   assign rf_read_data = rf_mem[rf_read_reg];

   always #5 clk = ~clk;

   block_transfer_sequencer #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .pre_index(pre_index),
      .up(up), .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr),
      .reg_list(reg_list), .busy(busy), .done(done), .rf_read_reg(rf_read_reg),
      .rf_read_data(rf_read_data), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .rf_reg_write(rf_reg_write), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL run%0d %s got=%h exp=%h", run_id, tag, got, exp);
      end
   endtask

   // One clock: sample at the falling edge, where the register file captures writes.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (rf_reg_write === 1'b1) begin
         rf_mem[rf_write_reg] = rf_write_data;
         wr_pulses++;
      end
   endtask

   task automatic chk_quiet(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_req"}, mem_req, 0);
      chk({pfx, "_we"}, mem_we, 0);
      chk({pfx, "_rfw"}, rf_reg_write, 0);
      chk({pfx, "_addr"}, mem_addr, 0);
      chk({pfx, "_wdat"}, rf_write_data, 0);
      chk({pfx, "_wreg"}, rf_write_reg, 0);
      chk({pfx, "_rreg"}, rf_read_reg, 0);
   endtask

   task automatic noise();
      start     = 1'($urandom_range(1, 0));
      is_load   = 1'($urandom_range(1, 0));
      pre_index = 1'($urandom_range(1, 0));
      up        = 1'($urandom_range(1, 0));
      writeback = 1'($urandom_range(1, 0));
      base_reg  = 4'($urandom);
      base_addr = $urandom;
      reg_list  = 16'($urandom);
   endtask

   task automatic run_xfer(input logic ld, input logic pre, input logic upd, input logic wb,
                           input logic [3:0] breg, input logic [N-1:0] base, input logic [15:0] list,
                           input int dlo, input int dhi, input logic [N-1:0] ld0);
      logic [N-1:0] exp_rf [16];
      logic [N-1:0] ex_addr [16];
      logic [N-1:0] ex_data [16];
      int ex_reg [16];
      int cnt, k, b, dly, gap_exp, last_ack, p0, budget;
      logic [N-1:0] first, fin;
      bit effwb, got_done, in_beat;

      run_id++;
      cnt = $countones(list);
      if (upd) begin
         first = pre ? base + 4 : base;
         fin   = base + 4 * cnt;
      end else begin
         first = pre ? base - 4 * cnt : base - 4 * cnt + 4;
         fin   = base - 4 * cnt;
      end
      for (int i = 0; i < 16; i++) exp_rf[i] = rf_mem[i];
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            ex_addr[k] = first + 4 * k;
            ex_reg[k]  = i;
            if (ld) ex_data[k] = (ld0 != 0) ? ld0 + k : $urandom;
            else    ex_data[k] = rf_mem[i];
            if (ld) exp_rf[i] = ex_data[k];
            k++;
         end
      end
      effwb = wb && (cnt != 0) && !(ld && list[breg]);
      if (effwb) exp_rf[breg] = fin;
      gap_exp = (cnt == 0) ? 1 : 1 + (ld ? 1 : 0) + (effwb ? 1 : 0);

      tick();
      is_load = ld; pre_index = pre; up = upd; writeback = wb;
      base_reg = breg; base_addr = base; reg_list = list; start = 1'b1;
      last_ack = cyc;
      p0 = wr_pulses; b = 0; dly = 0; in_beat = 0; got_done = 0;
      budget = cnt * (dhi + 3) + 8;
      for (int c = 0; c < budget && !got_done; c++) begin
         tick();
         chk("excl", mem_req & rf_reg_write, 0);
         mem_ack = 1'b0;
         if (done) begin
            got_done = 1;
            chk("gap", cyc - last_ack, gap_exp);
            chk("busy_at_done", busy, 0);
            start = 1'b0;
         end else begin
            if (cnt != 0) chk("busy", busy, 1);
            if (mem_req) begin
               if (b >= cnt) begin
                  chk("beat_count", b + 1, cnt);
               end else begin
                  if (!in_beat) begin
                     in_beat = 1;
                     dly = $urandom_range(dhi, dlo);
                  end
                  chk($sformatf("addr%0d", b), mem_addr, ex_addr[b]);
                  chk($sformatf("we%0d", b), mem_we, !ld);
                  if (!ld) chk($sformatf("rreg%0d", b), rf_read_reg, ex_reg[b]);
                  if (dly == 0) begin
                     mem_ack = 1'b1;
                     mem_rdata = ld ? ex_data[b] : $urandom;
                     if (!ld) chk($sformatf("wdata%0d", b), mem_wdata, ex_data[b]);
                     b++;
                     in_beat = 0;
                     if (b == cnt) last_ack = cyc;
                  end else begin
                     dly--;
                  end
               end
            end
            noise();
         end
      end
      mem_ack = 1'b0;
      start = 1'b0;
      if (!got_done) chk("done_timeout", 0, 1);
      tick();
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      chk("beats", b, cnt);
      chk("wr_pulses", wr_pulses - p0, (ld ? cnt : 0) + (effwb ? 1 : 0));
      for (int i = 0; i < 16; i++) chk($sformatf("rf%0d", i), rf_mem[i], exp_rf[i]);
   endtask

   logic [15:0]  t_list;
   logic [3:0]   t_breg;
   logic [N-1:0] t_base;
   int           t_nb, p_before;
   bit           t_found;

   initial begin
      for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
      rst = 1'b0;
      tick();
      tick();
      chk_quiet("reset");
      rst = 1'b1;

      // STM IA, r1/r2, immediate acks, no writeback.
      rf_mem[1] = 32'h11; rf_mem[2] = 32'h22;
      run_xfer(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'h100, 16'h0006, 0, 0, 32'h0);
      // LDM IB with writeback, r0 and r15.
      run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 32'h200, 16'h8001, 0, 0, 32'hA);
      // STM DB with writeback to r13.
      rf_mem[13] = 32'h300;
      run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h300, 16'h0007, 0, 1, 32'h0);
      // LDM with base in list, slow acks.
      rf_mem[3] = 32'h400;
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'h400, 16'h0019, 3, 3, 32'h77);
      // Empty list.
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 32'h500, 16'h0000, 0, 0, 32'h0);
      // Full-list DA store wrapping below zero.
      rf_mem[2] = 32'h8;
      run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h8, 16'hFFFF, 0, 1, 32'h0);

      // Reset during the second beat of a four-register load.
      run_id++;
      for (int i = 0; i < 16; i++) rf_mem[i] = 32'h1000 + i;
      tick();
      is_load = 1'b1; pre_index = 1'b0; up = 1'b1; writeback = 1'b1;
      base_reg = 4'd1; base_addr = 32'h800; reg_list = 16'h00F0; start = 1'b1;
      t_nb = 0; t_found = 0;
      for (int c = 0; c < 20 && !t_found; c++) begin
         tick();
         start = 1'b0;
         mem_ack = 1'b0;
         if (mem_req) begin
            if (t_nb == 0) begin
               mem_ack = 1'b1; mem_rdata = 32'hCAFE0004; t_nb = 1;
            end else begin
               t_found = 1;
            end
         end
      end
      chk("rst_reach_beat2", t_found, 1);
      p_before = wr_pulses;
      #2 rst = 1'b0;
      mem_ack = 1'b1;
      #1 chk_quiet("midrst");
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("midrst_hold", mem_req | rf_reg_write | busy, 0);
      end
      mem_ack = 1'b0;
      rst = 1'b1;
      tick();
      chk("midrst_idle", busy, 0);
      chk("midrst_writes", wr_pulses - p_before, 0);
      chk("midrst_r4", rf_mem[4], 32'hCAFE0004);
      chk("midrst_r5", rf_mem[5], 32'h1005);
      chk("midrst_r1", rf_mem[1], 32'h1001);
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h800, 16'h00F0, 0, 1, 32'h0);

      // Random transfers.
      for (int t = 0; t < 24; t++) begin
         t_list = 16'($urandom);
         if (t % 6 == 1) t_list = 16'h0001 << $urandom_range(15, 0);
         if (t == 9) t_list = 16'h0000;
         if (t == 14) t_list = 16'hFFFF;
         t_breg = 4'($urandom);
         t_base = $urandom;
         rf_mem[t_breg] = t_base;
         run_xfer(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)), t_breg, t_base, t_list, 0, 2, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
